tone_sequencer: RTL and testbench

Melody sequencer for the PmodAMP2 audio path: on a start request it plays a fixed eight-entry note table by driving a square-wave tone generator's half-period count and enable, and it owns the amplifier shutdown line. It sits between the user controls (switch/button logic) and the tone generator, which toggles its output every `tone_half_period` + 1 clocks while `tone_en` = 1. It replaces the direct switch-to-generator wiring.

---
 rtl/tone_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_tone_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// Melody sequencer: plays an eight-entry note table into a square-wave tone
// generator and owns the PmodAMP2 shutdown line while playback is active.
module tone_sequencer #(
    parameter int TICK_DIV = 100000,
    parameter int GAP_MS   = 20,
    parameter int WAKE_MS  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        loop,
    output logic [16:0] tone_half_period,
    output logic        tone_en,
    output logic        amp_shdn,
    output logic        busy,
    output logic        done,
    output logic [2:0]  note_idx
);

    typedef enum logic [1:0] {IDLE, WAKE, PLAY, GAP} state_t;

    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [15:0]   GAP_T      = 16'(GAP_MS);
    localparam logic [15:0]   WAKE_T     = 16'(WAKE_MS);

    function automatic logic [16:0] note_hp(input logic [2:0] i);
        case (i)
            3'd0:    note_hp = 17'd113636;
            3'd1:    note_hp = 17'd101238;
            3'd2:    note_hp = 17'd90193;
            3'd3:    note_hp = 17'd0;
            3'd4:    note_hp = 17'd75842;
            3'd5:    note_hp = 17'd90193;
            3'd6:    note_hp = 17'd56818;
            default: note_hp = 17'd113636;
        endcase
    endfunction

    function automatic logic [15:0] note_dur(input logic [2:0] i);
        case (i)
            3'd3:    note_dur = 16'd100;
            3'd4:    note_dur = 16'd400;
            3'd6:    note_dur = 16'd400;
            3'd7:    note_dur = 16'd600;
            default: note_dur = 16'd200;
        endcase
    endfunction

    state_t        state_reg, state_next;
    logic [2:0]    idx_reg, idx_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic [15:0]   ms_reg, ms_next;
    logic [16:0]   hp_reg, hp_next;
    logic          en_reg, en_next;
    logic          amp_reg, amp_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;

    logic          tick, expire, reload;
    logic [15:0]   ms_inc, target, dur_eff;
    state_t        ag_state;
    logic [2:0]    ag_idx;
    logic          ag_done;

    always_comb begin
        tick    = (presc_reg == PRESC_LAST);
        ms_inc  = ms_reg + 16'd1;
        dur_eff = (note_dur(idx_reg) == 16'd0) ? 16'd1 : note_dur(idx_reg);
        case (state_reg)
            WAKE:    target = WAKE_T;
            PLAY:    target = dur_eff;
            default: target = GAP_T;
        endcase
        expire = tick && (ms_inc == target);

        // Where playback goes once the silent gap after the current note ends.
        if (idx_reg != 3'd7) begin
            ag_state = PLAY;
            ag_idx   = idx_reg + 3'd1;
            ag_done  = 1'b0;
        end else if (loop) begin
            ag_state = PLAY;
            ag_idx   = 3'd0;
            ag_done  = 1'b0;
        end else begin
            ag_state = IDLE;
            ag_idx   = 3'd0;
            ag_done  = 1'b1;
        end

        state_next = state_reg;
        idx_next   = idx_reg;
        done_next  = 1'b0;
        reload     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && !stop) begin
                    reload   = 1'b1;
                    idx_next = 3'd0;
                    state_next = (WAKE_MS == 0) ? PLAY : WAKE;
                end
            end
            WAKE: begin
                if (expire) begin
                    reload     = 1'b1;
                    state_next = PLAY;
                    idx_next   = 3'd0;
                end
            end
            PLAY: begin
                if (expire) begin
                    reload = 1'b1;
                    if (GAP_MS == 0) begin
                        state_next = ag_state;
                        idx_next   = ag_idx;
                        done_next  = ag_done;
                    end else begin
                        state_next = GAP;
                    end
                end
            end
            default: begin
                if (expire) begin
                    reload     = 1'b1;
                    state_next = ag_state;
                    idx_next   = ag_idx;
                    done_next  = ag_done;
                end
            end
        endcase

        if (stop && state_reg != IDLE) begin
            state_next = IDLE;
            idx_next   = 3'd0;
            done_next  = 1'b0;
            reload     = 1'b1;
        end

        if (reload || state_reg == IDLE) begin
            presc_next = '0;
            ms_next    = 16'd0;
        end else if (tick) begin
            presc_next = '0;
            ms_next    = ms_inc;
        end else begin
            presc_next = presc_reg + 1'b1;
            ms_next    = ms_reg;
        end

        // Outputs are decoded from the next state so they leave the flops aligned with it.
        case (state_next)
            IDLE:    hp_next = 17'd0;
            PLAY:    hp_next = note_hp(idx_next);
            default: hp_next = hp_reg;
        endcase
        en_next   = (state_next == PLAY) && (note_hp(idx_next) != 17'd0);
        amp_next  = (state_next != IDLE);
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= 3'd0;
            presc_reg <= '0;
            ms_reg    <= 16'd0;
            hp_reg    <= 17'd0;
            en_reg    <= 1'b0;
            amp_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            presc_reg <= presc_next;
            ms_reg    <= ms_next;
            hp_reg    <= hp_next;
            en_reg    <= en_next;
            amp_reg   <= amp_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign tone_half_period = hp_reg;
    assign tone_en          = en_reg;
    assign amp_shdn         = amp_reg;
    assign busy             = busy_reg;
    assign done             = done_reg;
    assign note_idx         = idx_reg;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with a 10-clock ms tick; scenarios run
// back to back, each continuing from where the previous one left the DUT.
module tb_tone_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop = 1'b0;
    logic [16:0] tone_half_period;
    logic        tone_en;
    logic        amp_shdn;
    logic        busy;
    logic        done;
    logic [2:0]  note_idx;

    int n_checks = 0;
    int n_fail   = 0;

    tone_sequencer #(.TICK_DIV(10), .GAP_MS(20), .WAKE_MS(1)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .stop             (stop),
        .loop             (loop),
        .tone_half_period (tone_half_period),
        .tone_en          (tone_en),
        .amp_shdn         (amp_shdn),
        .busy             (busy),
        .done             (done),
        .note_idx         (note_idx)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0d expected 0", busy); end
        n_checks++; if (tone_en !== 1'b0) begin n_fail++; $display("FAIL rst_en: got %0d expected 0", tone_en); end
        n_checks++; if (amp_shdn !== 1'b0) begin n_fail++; $display("FAIL rst_amp: got %0d expected 0", amp_shdn); end
        n_checks++; if (tone_half_period !== 17'd0) begin n_fail++; $display("FAIL rst_hp: got %0d expected 0", tone_half_period); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0d expected 0", done); end
        n_checks++; if (note_idx !== 3'd0) begin n_fail++; $display("FAIL rst_idx: got %0d expected 0", note_idx); end
        repeat (3) step();
        rst = 1'b0;
        repeat (5) step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %0d expected 0", busy); end
    endtask

    // Sample index c counts cycles after the edge that accepted start.
    task automatic test_full_run();
        int busy_cnt = 0;
        int done_cnt = 0;
        int rest_bad = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 24610; c++) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (c == 0) begin
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start_busy: got %0d expected 1", busy); end
                n_checks++; if (amp_shdn !== 1'b1) begin n_fail++; $display("FAIL start_amp: got %0d expected 1", amp_shdn); end
                n_checks++; if (tone_en !== 1'b0) begin n_fail++; $display("FAIL wake_en: got %0d expected 0", tone_en); end
            end
            if (c == 9) begin
                n_checks++; if (tone_en !== 1'b0) begin n_fail++; $display("FAIL wake_end_en: got %0d expected 0", tone_en); end
            end
            if (c == 10 || c == 2009) begin
                n_checks++; if (tone_en !== 1'b1) begin n_fail++; $display("FAIL note0_en c=%0d: got %0d expected 1", c, tone_en); end
                n_checks++; if (tone_half_period !== 17'd113636) begin n_fail++; $display("FAIL note0_hp c=%0d: got %0d expected 113636", c, tone_half_period); end
                n_checks++; if (note_idx !== 3'd0) begin n_fail++; $display("FAIL note0_idx c=%0d: got %0d expected 0", c, note_idx); end
            end
            if (c == 2010 || c == 2209) begin
                n_checks++; if (tone_en !== 1'b0) begin n_fail++; $display("FAIL gap0_en c=%0d: got %0d expected 0", c, tone_en); end
                n_checks++; if (tone_half_period !== 17'd113636) begin n_fail++; $display("FAIL gap0_hp c=%0d: got %0d expected 113636", c, tone_half_period); end
            end
            if (c == 2210) begin
                n_checks++; if (tone_en !== 1'b1) begin n_fail++; $display("FAIL note1_en: got %0d expected 1", tone_en); end
                n_checks++; if (tone_half_period !== 17'd101238) begin n_fail++; $display("FAIL note1_hp: got %0d expected 101238", tone_half_period); end
                n_checks++; if (note_idx !== 3'd1) begin n_fail++; $display("FAIL note1_idx: got %0d expected 1", note_idx); end
            end
            if (c == 6610) begin
                n_checks++; if (note_idx !== 3'd3) begin n_fail++; $display("FAIL rest_idx: got %0d expected 3", note_idx); end
                n_checks++; if (tone_half_period !== 17'd0) begin n_fail++; $display("FAIL rest_hp: got %0d expected 0", tone_half_period); end
            end
            if (c >= 6610 && c <= 7809) begin
                if (tone_en || !amp_shdn || !busy) rest_bad++;
            end
            if (c == 7810) begin
                n_checks++; if (tone_en !== 1'b1) begin n_fail++; $display("FAIL note4_en: got %0d expected 1", tone_en); end
                n_checks++; if (tone_half_period !== 17'd75842) begin n_fail++; $display("FAIL note4_hp: got %0d expected 75842", tone_half_period); end
                n_checks++; if (note_idx !== 3'd4) begin n_fail++; $display("FAIL note4_idx: got %0d expected 4", note_idx); end
            end
            if (c == 24609) begin
                n_checks++; if (note_idx !== 3'd7) begin n_fail++; $display("FAIL last_idx: got %0d expected 7", note_idx); end
            end
            // Stray one-cycle start pulses while busy must not disturb timing.
            start = (c == 3000 || c == 12000);
            if (c < 24609) step();
        end
        start = 1'b0;
        n_checks++; if (busy_cnt !== 24610) begin n_fail++; $display("FAIL busy_time: got %0d expected 24610", busy_cnt); end
        n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL early_done: got %0d expected 0", done_cnt); end
        n_checks++; if (rest_bad !== 0) begin n_fail++; $display("FAIL rest_window: got %0d bad cycles expected 0", rest_bad); end
    endtask

    // Continues from the last busy cycle of the previous run.
    task automatic test_start_held();
        start = 1'b1;
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL end_busy: got %0d expected 0", busy); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL end_done: got %0d expected 1", done); end
        n_checks++; if (amp_shdn !== 1'b0) begin n_fail++; $display("FAIL end_amp: got %0d expected 0", amp_shdn); end
        n_checks++; if (tone_half_period !== 17'd0) begin n_fail++; $display("FAIL end_hp: got %0d expected 0", tone_half_period); end
        n_checks++; if (note_idx !== 3'd0) begin n_fail++; $display("FAIL end_idx: got %0d expected 0", note_idx); end
        step();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy: got %0d expected 1", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_width: got %0d expected 0", done); end
        n_checks++; if (amp_shdn !== 1'b1) begin n_fail++; $display("FAIL restart_amp: got %0d expected 1", amp_shdn); end
    endtask

    // d=0 is the first WAKE cycle of the held-start playback; start stays high.
    task automatic test_loop();
        int idle_cnt = 0;
        int done_cnt = 0;
        loop = 1'b1;
        for (int d = 0; d <= 49220; d++) begin
            if (!busy || !amp_shdn) idle_cnt++;
            if (done) done_cnt++;
            if (d == 24609) begin
                n_checks++; if (note_idx !== 3'd7) begin n_fail++; $display("FAIL wrap_pre_idx: got %0d expected 7", note_idx); end
                n_checks++; if (tone_en !== 1'b0) begin n_fail++; $display("FAIL wrap_pre_en: got %0d expected 0", tone_en); end
            end
            if (d == 10 || d == 24610 || d == 49210) begin
                n_checks++; if (note_idx !== 3'd0) begin n_fail++; $display("FAIL wrap_idx d=%0d: got %0d expected 0", d, note_idx); end
                n_checks++; if (tone_half_period !== 17'd113636) begin n_fail++; $display("FAIL wrap_hp d=%0d: got %0d expected 113636", d, tone_half_period); end
                n_checks++; if (tone_en !== 1'b1) begin n_fail++; $display("FAIL wrap_en d=%0d: got %0d expected 1", d, tone_en); end
            end
            if (d < 49220) step();
        end
        n_checks++; if (idle_cnt !== 0) begin n_fail++; $display("FAIL loop_busy_drop: got %0d cycles expected 0", idle_cnt); end
        n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL loop_done: got %0d expected 0", done_cnt); end
    endtask

    task automatic test_stop();
        int cnt = 0;
        int bad = 0;
        loop  = 1'b0;
        start = 1'b0;
        while (note_idx != 3'd4 && cnt < 10000) begin
            step();
            cnt++;
        end
        n_checks++; if (note_idx !== 3'd4) begin n_fail++; $display("FAIL reach_idx4: got %0d expected 4", note_idx); end
        repeat (100) step();
        n_checks++; if (tone_half_period !== 17'd75842) begin n_fail++; $display("FAIL pre_stop_hp: got %0d expected 75842", tone_half_period); end
        stop = 1'b1;
        step();
        stop = 1'b0;
        n_checks++; if (tone_en !== 1'b0) begin n_fail++; $display("FAIL stop_en: got %0d expected 0", tone_en); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_busy: got %0d expected 0", busy); end
        n_checks++; if (amp_shdn !== 1'b0) begin n_fail++; $display("FAIL stop_amp: got %0d expected 0", amp_shdn); end
        n_checks++; if (tone_half_period !== 17'd0) begin n_fail++; $display("FAIL stop_hp: got %0d expected 0", tone_half_period); end
        n_checks++; if (note_idx !== 3'd0) begin n_fail++; $display("FAIL stop_idx: got %0d expected 0", note_idx); end
        for (int i = 0; i < 20; i++) begin
            if (i == 0 || busy || done) bad += (busy || done) ? 1 : 0;
            step();
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL stop_quiet: got %0d bad cycles expected 0", bad); end
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL replay_busy: got %0d expected 1", busy); end
        repeat (9) step();
        n_checks++; if (tone_en !== 1'b0) begin n_fail++; $display("FAIL replay_wake: got %0d expected 0", tone_en); end
        step();
        n_checks++; if (tone_en !== 1'b1) begin n_fail++; $display("FAIL replay_en: got %0d expected 1", tone_en); end
        n_checks++; if (note_idx !== 3'd0) begin n_fail++; $display("FAIL replay_idx: got %0d expected 0", note_idx); end
        n_checks++; if (tone_half_period !== 17'd113636) begin n_fail++; $display("FAIL replay_hp: got %0d expected 113636", tone_half_period); end
    endtask

    task automatic test_async_reset();
        int bad = 0;
        repeat (100) step();
        #3;
        rst = 1'b1;
        #1;
        n_checks++; if (tone_en !== 1'b0) begin n_fail++; $display("FAIL arst_en: got %0d expected 0", tone_en); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %0d expected 0", busy); end
        n_checks++; if (amp_shdn !== 1'b0) begin n_fail++; $display("FAIL arst_amp: got %0d expected 0", amp_shdn); end
        n_checks++; if (tone_half_period !== 17'd0) begin n_fail++; $display("FAIL arst_hp: got %0d expected 0", tone_half_period); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL arst_done: got %0d expected 0", done); end
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (busy || tone_en || amp_shdn) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL post_rst_idle: got %0d bad cycles expected 0", bad); end
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL post_rst_start: got %0d expected 1", busy); end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_start_held();
        test_loop();
        test_stop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
